// File: rtl/ultrasonic_responder.sv
`timescale 1ns/1ps
// Purpose : emulates an ultrasonic ranging sensor; a valid trigger pulse from the
//           master is answered by an echo pulse whose width encodes a target distance.
// Latency : echo rises BURST_DLY_CYC+3 clocks after the first clk edge that samples trig low.
// Backpressure : none; triggers arriving while busy are ignored and malformed triggers raise trig_err.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   trig         asynchronous trigger from the ranging master
//   distance_cm  emulated target distance in cm, latched when a trigger is accepted
//   obj_present  1 = a target exists, 0 = no echo return (timeout-width echo)
//   echo         registered echo pulse to the master
//   busy         high whenever the responder is not idle
//   trig_err     one-cycle pulse when a trigger is rejected (too short or too long)
//   ping_cnt     count of completed echoes, wraps at 255
//
// Optional build macro ECHO_JITTER_EN: adds 0..15 cycles of pseudo-random jitter to
// every echo width, taken from an 8-bit LFSR that advances on each accepted trigger.

module ultrasonic_responder #(
    parameter int unsigned CYC_PER_CM    = 1566,
    parameter int unsigned TRIG_MIN_CYC  = 270,
    parameter int unsigned TRIG_MAX_CYC  = 27000,
    parameter int unsigned BURST_DLY_CYC = 5400,
    parameter int unsigned ECHO_TMO_CYC  = 1026000,
    parameter int unsigned HOLDOFF_CYC   = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    input  logic       obj_present,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic [7:0] ping_cnt
);

    // All durations are handled as 20-bit quantities; 400 cm * 1566 and the
    // 38 ms timeout both fit below 2^20 at the default parameters.
    localparam logic [19:0] CYC_PER_CM_W = 20'(CYC_PER_CM);
    localparam logic [19:0] TRIG_MIN_W   = 20'(TRIG_MIN_CYC);
    localparam logic [19:0] TRIG_MAX_W   = 20'(TRIG_MAX_CYC);
    localparam logic [19:0] BURST_DLY_W  = 20'(BURST_DLY_CYC);
    localparam logic [19:0] ECHO_TMO_W   = 20'(ECHO_TMO_CYC);
    localparam logic [19:0] HOLDOFF_W    = 20'(HOLDOFF_CYC);

    localparam logic [8:0] DIST_MIN = 9'd2;
    localparam logic [8:0] DIST_MAX = 9'd400;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLD    = 3'd4,
        S_WAITLOW = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic        trig_s1_q,   trig_s1_d;     // first synchronizer stage
    logic        trig_s2_q,   trig_s2_d;     // synchronized trig
    logic        trig_prev_q, trig_prev_d;   // previous synchronized value
    logic        rise_q,      rise_d;        // registered edge pulses
    logic        fall_q,      fall_d;
    logic [19:0] cnt_q,       cnt_d;         // shared duration counter
    logic [8:0]  dist_q,      dist_d;        // distance latched at trigger accept
    logic        obj_q,       obj_d;
    logic        echo_q,      echo_d;
    logic        busy_q,      busy_d;
    logic        trig_err_q,  trig_err_d;
    logic [7:0]  ping_q,      ping_d;

`ifdef ECHO_JITTER_EN
    logic [7:0]  lfsr_q,      lfsr_d;
    logic [7:0]  lfsr_next;
`endif

    // ------------------------------------------------------------------
    // Echo width from the latched target.  Out-of-range or absent targets
    // produce the timeout width; near targets are clamped to 2 cm.
    // ------------------------------------------------------------------
    logic [8:0]  dist_clamped;
    logic [19:0] width_base;
    logic [19:0] width_eff;

    always_comb begin
        dist_clamped = (dist_q < DIST_MIN) ? DIST_MIN : dist_q;
        if (!obj_q || (dist_q > DIST_MAX)) begin
            width_base = ECHO_TMO_W;
        end else begin
            width_base = 20'(dist_clamped) * CYC_PER_CM_W;
        end
`ifdef ECHO_JITTER_EN
        width_eff = width_base + {16'd0, lfsr_q[3:0]};
`else
        width_eff = width_base;
`endif
    end

`ifdef ECHO_JITTER_EN
    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
    always_comb begin
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dist_d      = dist_q;
        obj_d       = obj_q;
        echo_d      = echo_q;
        ping_d      = ping_q;
        trig_err_d  = 1'b0;
`ifdef ECHO_JITTER_EN
        lfsr_d      = lfsr_q;
`endif

        trig_s1_d   = trig;
        trig_s2_d   = trig_s1_q;
        trig_prev_d = trig_s2_q;

        // A rise only counts when it is seen while idle, so a trigger that went
        // high during HOLD (or any busy state) never starts a new cycle.
        rise_d = trig_s2_q & ~trig_prev_q & (state_q == S_IDLE);
        fall_d = ~trig_s2_q & trig_prev_q;

        case (state_q)
            S_IDLE: begin
                if (rise_q) begin
                    state_d = S_TRIG;
                    cnt_d   = 20'd1;
                end
            end

            S_TRIG: begin
                // cnt_q equals the number of raw high cycles when the fall arrives.
                // A fall takes priority over the max check, so a pulse of exactly
                // TRIG_MAX_CYC is still accepted.
                if (fall_q) begin
                    if (cnt_q >= TRIG_MIN_W) begin
                        state_d = S_BURST;
                        cnt_d   = 20'd1;
                        dist_d  = distance_cm;
                        obj_d   = obj_present;
`ifdef ECHO_JITTER_EN
                        lfsr_d  = lfsr_next;
`endif
                    end else begin
                        state_d    = S_IDLE;
                        cnt_d      = 20'd0;
                        trig_err_d = 1'b1;
                    end
                end else if (cnt_q >= TRIG_MAX_W) begin
                    state_d    = S_WAITLOW;
                    cnt_d      = 20'd0;
                    trig_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_BURST: begin
                if (cnt_q >= BURST_DLY_W) begin
                    state_d = S_ECHO;
                    cnt_d   = 20'd1;
                    echo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_ECHO: begin
                if (cnt_q >= width_eff) begin
                    state_d = S_HOLD;
                    cnt_d   = 20'd1;
                    echo_d  = 1'b0;
                    ping_d  = ping_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_HOLD: begin
                if (cnt_q >= HOLDOFF_W) begin
                    state_d = S_IDLE;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_WAITLOW: begin
                if (!trig_s2_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 20'd0;
                echo_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cnt_q       <= 20'd0;
            dist_q      <= 9'd0;
            obj_q       <= 1'b0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            trig_err_q  <= 1'b0;
            ping_q      <= 8'd0;
`ifdef ECHO_JITTER_EN
            lfsr_q      <= 8'hA5;
`endif
        end else begin
            state_q     <= state_d;
            trig_s1_q   <= trig_s1_d;
            trig_s2_q   <= trig_s2_d;
            trig_prev_q <= trig_prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            cnt_q       <= cnt_d;
            dist_q      <= dist_d;
            obj_q       <= obj_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            trig_err_q  <= trig_err_d;
            ping_q      <= ping_d;
`ifdef ECHO_JITTER_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = trig_err_q;
    assign ping_cnt = ping_q;

endmodule

// File: tb/tb_ultrasonic_responder.sv
`timescale 1ns/1ps
// Testbench for ultrasonic_responder with shortened timing parameters.
// Stimulus pushes expected responses into a scoreboard; a monitor pops them
// whenever the DUT raises echo or trig_err.

module tb_ultrasonic_responder;

    localparam int CPC  = 3;
    localparam int TMIN = 12;
    localparam int TMAX = 150;
    localparam int BDLY = 20;
    localparam int TMO  = 1500;
    localparam int HOLD = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [8:0] distance_cm = 9'd10;
    logic       obj_present = 1'b1;
    logic       echo;
    logic       busy;
    logic       trig_err;
    logic [7:0] ping_cnt;

    ultrasonic_responder #(
        .CYC_PER_CM   (CPC),
        .TRIG_MIN_CYC (TMIN),
        .TRIG_MAX_CYC (TMAX),
        .BURST_DLY_CYC(BDLY),
        .ECHO_TMO_CYC (TMO),
        .HOLDOFF_CYC  (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .distance_cm(distance_cm),
        .obj_present(obj_present),
        .echo       (echo),
        .busy       (busy),
        .trig_err   (trig_err),
        .ping_cnt   (ping_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int exp_edge;
        int width;     // -1: pulse will be cut by reset, width/ping not checked
        int ping;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_ping   = 0;
    logic [7:0] m_lfsr = 8'hA5;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: echo width from the target description.
    function automatic int model_width(input int d, input bit o, input logic [7:0] l);
        int w;
        if (!o || d > 400) w = TMO;
        else               w = ((d < 2) ? 2 : d) * CPC;
`ifdef ECHO_JITTER_EN
        w = w + int'(l[3:0]);
`else
        if (l == 8'h00) w = w + 0;
`endif
        return w;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Drive a trigger of n cycles without any expectation (trigger must be ignored).
    task automatic raw_trig(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
    endtask

    // Drive a trigger of n cycles and push the expected response.
    task automatic do_trig(input int n, input bit abort);
        exp_t e;
        int   start, rise_e, fall_e;
        @(negedge clk);
        start  = cyc;
        rise_e = start + 1;      // first posedge sampling trig high
        fall_e = start + 1 + n;  // first posedge sampling trig low
        if (n < TMIN) begin
            e = '{1'b1, fall_e + 3, 0, 0};
        end else if (n > TMAX) begin
            e = '{1'b1, rise_e + TMAX + 3, 0, 0};
        end else begin
            m_lfsr = lfsr_step(m_lfsr);
            if (abort) begin
                e = '{1'b0, fall_e + BDLY + 3, -1, 0};
            end else begin
                m_ping = (m_ping + 1) % 256;
                e = '{1'b0, fall_e + BDLY + 3,
                      model_width(int'(distance_cm), obj_present, m_lfsr), m_ping};
            end
        end
        sb.push_back(e);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        if (n > TMAX + 5) chk("busy_in_waitlow", int'(busy), 1);
        trig = 1'b0;
        // Scramble the target after it has been latched.
        repeat (6) @(negedge clk);
        distance_cm = 9'($urandom_range(0, 511));
        obj_present = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 4000);
        chk(name, int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_echo(input logic lvl, input string name);
        int k = 0;
        while (echo !== lvl && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(echo), int'(lvl));
    endtask

    // Monitor: pops the scoreboard whenever the DUT produces a response.
    bit   in_echo = 1'b0;
    int   mon_w   = 0;
    exp_t cur;
    exp_t cur_err;

    initial begin
        forever begin
            @(negedge clk);
            if (trig_err) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_trig_err: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    cur_err = sb.pop_front();
                    chk("resp_is_err", int'(cur_err.is_err), 1);
                    chk("err_edge", cyc, cur_err.exp_edge);
                end
            end
            if (echo && !in_echo) begin
                in_echo = 1'b1;
                mon_w   = 1;
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_echo: got 1 expected 0 (cycle %0d)", cyc);
                    cur = '{1'b0, 0, -1, 0};
                end else begin
                    cur = sb.pop_front();
                    chk("resp_is_echo", int'(cur.is_err), 0);
                    chk("echo_rise_edge", cyc, cur.exp_edge);
                end
            end else if (echo && in_echo) begin
                mon_w++;
            end else if (!echo && in_echo) begin
                in_echo = 1'b0;
                if (cur.width >= 0) begin
                    chk("echo_width", mon_w, cur.width);
                    chk("ping_after_echo", int'(ping_cnt), cur.ping);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_trig_err", int'(trig_err), 0);
        chk("rst_ping", int'(ping_cnt), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal ping at minimum accepted trigger
        distance_cm = 9'd10; obj_present = 1'b1;
        do_trig(TMIN, 1'b0);
        wait_idle("idle_nominal");

        // Too-short triggers
        do_trig(TMIN - 1, 1'b0);
        wait_idle("idle_short");
        chk("ping_after_reject", int'(ping_cnt), m_ping);
        do_trig(1, 1'b0);
        wait_idle("idle_short1");

        // Longest accepted and too-long triggers
        distance_cm = 9'd50; obj_present = 1'b1;
        do_trig(TMAX, 1'b0);
        wait_idle("idle_tmax");
        do_trig(TMAX + 1, 1'b0);
        wait_idle("idle_tmax_p1");
        do_trig(TMAX + 40, 1'b0);
        wait_idle("idle_long");

        // Width boundaries: no object, far, near clamp, range edges
        distance_cm = 9'd10;  obj_present = 1'b0; do_trig(TMIN + 2, 1'b0); wait_idle("idle_noobj");
        distance_cm = 9'd500; obj_present = 1'b1; do_trig(TMIN + 2, 1'b0); wait_idle("idle_d500");
        distance_cm = 9'd1;   obj_present = 1'b1; do_trig(TMIN + 2, 1'b0); wait_idle("idle_d1");
        distance_cm = 9'd0;   obj_present = 1'b1; do_trig(TMIN + 2, 1'b0); wait_idle("idle_d0");
        distance_cm = 9'd400; obj_present = 1'b1; do_trig(TMIN + 2, 1'b0); wait_idle("idle_d400");
        distance_cm = 9'd401; obj_present = 1'b1; do_trig(TMIN + 2, 1'b0); wait_idle("idle_d401");

        // Randomized transactions
        for (int i = 0; i < 16; i++) begin
            int sel, n;
            sel = $urandom_range(0, 5);
            if (sel == 0)      n = $urandom_range(1, TMIN - 1);
            else if (sel == 1) n = $urandom_range(TMAX + 6, TMAX + 30);
            else               n = $urandom_range(TMIN, TMAX);
            distance_cm = 9'($urandom_range(0, 511));
            obj_present = ($urandom_range(0, 3) != 0);
            do_trig(n, 1'b0);
            wait_idle("idle_random");
        end

        // Triggers during HOLD and straddling its exit are ignored
        distance_cm = 9'd10; obj_present = 1'b1;
        do_trig(TMIN, 1'b0);
        wait_echo(1'b1, "hold_echo_rise");
        wait_echo(1'b0, "hold_echo_fall");
        repeat (2) @(negedge clk);
        raw_trig(TMIN + 5);
        repeat (25) @(negedge clk);
        raw_trig(30);
        repeat (10) @(negedge clk);
        chk("busy_after_hold_trigs", int'(busy), 0);
        chk("ping_after_hold_trigs", int'(ping_cnt), m_ping);

        // Fast pings to carry ping_cnt through its wrap
        for (int i = 0; i < 250; i++) begin
            distance_cm = 9'd2; obj_present = 1'b1;
            do_trig(TMIN, 1'b0);
            wait_idle("idle_wrap");
        end

        // Reset in the middle of an echo
        distance_cm = 9'd100; obj_present = 1'b1;
        do_trig(TMIN, 1'b1);
        wait_echo(1'b1, "abort_echo_rise");
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_echo", int'(echo), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ping", int'(ping_cnt), 0);
        chk("abort_trig_err", int'(trig_err), 0);
        m_ping = 0;
        m_lfsr = 8'hA5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_ping_after", int'(ping_cnt), 0);

        // Normal operation resumes after reset
        distance_cm = 9'd10; obj_present = 1'b1;
        do_trig(TMIN + 3, 1'b0);
        wait_idle("idle_post_reset");

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
